pipe_hold_ctrl: RTL
===================

Name: pipe_hold_ctrl

Overview:
- Central hold/flush sequencer for the 5-stage MIPS pipeline.
- Drives EN/CLR of the F/D, D/E, E/M and M/W stage registers.
- Arbitrates between three event sources: a multi-cycle data-memory handshake, the load-use hazard, and a branch/jump redirect.
- Sits beside the hazard unit. Consumes its load_use_D and redirect_D flags plus the memory ready line.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles before an access is abandoned; legal range 2..65535.
- CNT_W, 16: width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_access_M  in  1  load or store in M stage this cycle.
- mem_ready  in  1  data memory completes the current access this cycle.
- load_use_D  in  1  hazard unit: D-stage instruction needs a load result not yet available.
- redirect_D  in  1  branch taken / J / JR resolved in D.
- mem_req  out  1  access request to data memory.
- EN_FD, EN_DE, EN_EM, EN_MW  out  1 each  stage-register enables.
- CLR_FD, CLR_DE, CLR_MW  out  1 each  synchronous bubble insert.
- mem_err  out  1  one-cycle pulse on access timeout.
- stall_cnt  out  CNT_W  saturating count of memory-stall cycles.

Behaviour:
- FSM states: IDLE, WAIT, ERR. Timeout counter wcnt is 16 bits wide.
- Reset (async): state=IDLE, wcnt=0, stall_cnt=0, mem_err=0.
  - While rst is high: mem_req=0, all EN=1, all CLR=1.
- Releasing reset mid-access: the access is discarded and the FSM restarts in IDLE.
- IDLE:
  - mem_req = mem_access_M.
  - If mem_access_M && mem_ready: zero-wait access; no memory stall.
  - If mem_access_M && !mem_ready:
    - Next state WAIT, wcnt<=1.
    - This cycle: EN_FD=EN_DE=EN_EM=EN_MW=0 and CLR_MW=1.
- WAIT:
  - mem_req=1. All EN=0, CLR_MW=1, stall_cnt increments (saturating at all-ones).
  - On mem_ready: return to IDLE. All EN=1 and CLR_MW=0 that cycle, so M/W captures the completed access.
  - If !mem_ready and wcnt==TIMEOUT-1: go to ERR. Otherwise wcnt++.
  - mem_access_M is ignored in WAIT; it is held stable by EN_EM=0.
- ERR (one cycle):
  - mem_req=0, mem_err=1, CLR_MW=1, all EN=1.
  - The faulting instruction is dropped; next state IDLE, wcnt=0.
- Priority, highest first: memory stall (IDLE-miss or WAIT) > ERR > load_use_D > redirect_D.
- load_use_D (no memory stall):
  - EN_FD=EN_DE=0, CLR_DE=1; EN_EM=EN_MW=1.
  - redirect_D is suppressed that cycle; the hazard unit re-asserts it after the stall.
- redirect_D alone: CLR_FD=1, all EN=1.
- No event active: all EN=1, all CLR=0.
- Load-use/redirect outputs are combinational from inputs and state. No added latency.
- Memory stall is visible in the same cycle as the miss, because mem_ready is sampled combinationally.
- CLR has priority over EN inside the stage registers. The controller never asserts CLR_FD together with EN_FD=0.
- stall_cnt increments in both the IDLE-miss cycle and every WAIT cycle, saturating.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, ERR=2'd2);
  - default TIMEOUT constant;
  - an enable/clear bundle struct shared with the stage registers.
- One natural sub-module: sat_counter, the parameterised saturating up-counter with increment and clear. It is used for stall_cnt and reusable for other perf counters.
- The FSM and priority encoder stay in pipe_hold_ctrl.

Test Plan:
1. Zero-wait: mem_access_M=1, mem_ready=1 in the same cycle.
   - mem_req=1, all EN=1, CLR_MW=0, state stays IDLE, stall_cnt=0.
2. Three-wait access: mem_access_M=1, mem_ready low for 3 cycles then high.
   - EN_*=0 and CLR_MW=1 for 3 cycles.
   - 4th cycle: EN_*=1, CLR_MW=0.
   - stall_cnt=3, IDLE after.
3. Timeout with TIMEOUT=4: mem_access_M=1, mem_ready never asserted.
   - Stall for 4 cycles, then one ERR cycle: mem_err=1, mem_req=0, CLR_MW=1.
   - Then IDLE; stall_cnt=4.
4. Load-use plus redirect in the same cycle, no memory access.
   - EN_FD=EN_DE=0, CLR_DE=1, CLR_FD=0.
   - Next cycle with redirect_D alone: CLR_FD=1.
5. Memory miss while load_use_D=1 and redirect_D=1.
   - Memory stall pattern only: all EN=0, CLR_MW=1, CLR_DE=0, CLR_FD=0.
6. rst pulsed high during the 2nd WAIT cycle.
   - Immediate mem_req=0, all EN=1, all CLR=1, stall_cnt=0.
   - After release: IDLE, new access accepted normally.
   - Also: stall_cnt with CNT_W=2 saturates at 3.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hold/flush sequencer and stage registers.
// Holds FSM encoding, default timeout and the enable/clear bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam int TIMEOUT_DEF = 16;
    localparam int WCNT_W      = 16;

    // Per-stage enable/clear bundle consumed by the stage registers.
    typedef struct packed {
        logic en_fd;
        logic en_de;
        logic en_em;
        logic en_mw;
        logic clr_fd;
        logic clr_de;
        logic clr_mw;
    } hold_ctl_t;

    localparam hold_ctl_t CTL_RUN = '{
        en_fd: 1'b1, en_de: 1'b1,
        en_em: 1'b1, en_mw: 1'b1,
        clr_fd: 1'b0, clr_de: 1'b0,
        clr_mw: 1'b0
    };

    localparam hold_ctl_t CTL_STALL = '{
        en_fd: 1'b0, en_de: 1'b0,
        en_em: 1'b0, en_mw: 1'b0,
        clr_fd: 1'b0, clr_de: 1'b0,
        clr_mw: 1'b1
    };

    localparam hold_ctl_t CTL_ERR = '{
        en_fd: 1'b1, en_de: 1'b1,
        en_em: 1'b1, en_mw: 1'b1,
        clr_fd: 1'b0, clr_de: 1'b0,
        clr_mw: 1'b1
    };

    localparam hold_ctl_t CTL_LU = '{
        en_fd: 1'b0, en_de: 1'b0,
        en_em: 1'b1, en_mw: 1'b1,
        clr_fd: 1'b0, clr_de: 1'b1,
        clr_mw: 1'b0
    };

    localparam hold_ctl_t CTL_RD = '{
        en_fd: 1'b1, en_de: 1'b1,
        en_em: 1'b1, en_mw: 1'b1,
        clr_fd: 1'b1, clr_de: 1'b0,
        clr_mw: 1'b0
    };

    localparam hold_ctl_t CTL_RST = '{
        en_fd: 1'b1, en_de: 1'b1,
        en_em: 1'b1, en_mw: 1'b1,
        clr_fd: 1'b1, clr_de: 1'b1,
        clr_mw: 1'b1
    };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (perf counters).
// Ports: clk, rst (async high), clr, inc -> cnt[W-1:0], sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Hold/flush sequencer: memory wait FSM plus load-use/redirect priority.
// In: mem_access_M, mem_ready, load_use_D, redirect_D. Out: mem_req,
// EN_*/CLR_* stage controls, mem_err pulse, stall_cnt perf counter.
module pipe_hold_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_access_M,
    input  logic             mem_ready,
    input  logic             load_use_D,
    input  logic             redirect_D,
    output logic             mem_req,
    output logic             EN_FD,
    output logic             EN_DE,
    output logic             EN_EM,
    output logic             EN_MW,
    output logic             CLR_FD,
    output logic             CLR_DE,
    output logic             CLR_MW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_nxt;
    hold_ctl_t         ctl;

    logic stall_m;
    logic in_err;
    logic sel_stl;
    logic sel_err;
    logic sel_lu;
    logic sel_rd;

    // Memory stall is seen in the miss cycle itself since mem_ready
    // is sampled combinationally.
    assign stall_m = ((state == IDLE) && mem_access_M && !mem_ready)
                   || ((state == WAIT) && !mem_ready);
    assign in_err  = (state == ERR);

    // Mutually exclusive selects so the decoder below stays unique.
    assign sel_stl = stall_m;
    assign sel_err = in_err && !stall_m;
    assign sel_lu  = load_use_D && !stall_m && !in_err;
    assign sel_rd  = redirect_D && !load_use_D
                   && !stall_m && !in_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        mem_req   = 1'b0;
        mem_err   = 1'b0;
        ctl       = CTL_RUN;

        unique case (state)
            IDLE: begin
                mem_req = mem_access_M;
                if (mem_access_M && !mem_ready) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = WCNT_W'(1);
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_nxt = IDLE;
                    wcnt_nxt  = '0;
                end else if (wcnt == WLAST) begin
                    state_nxt = ERR;
                    wcnt_nxt  = '0;
                end else begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end
            end
            ERR: begin
                mem_err   = 1'b1;
                state_nxt = IDLE;
                wcnt_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
                wcnt_nxt  = '0;
            end
        endcase

        unique case (1'b1)
            sel_stl: ctl = CTL_STALL;
            sel_err: ctl = CTL_ERR;
            sel_lu:  ctl = CTL_LU;
            sel_rd:  ctl = CTL_RD;
            default: ctl = CTL_RUN;
        endcase

        // Reset forces every stage register to flush.
        if (rst) begin
            mem_req = 1'b0;
            mem_err = 1'b0;
            ctl     = CTL_RST;
        end
    end

    assign EN_FD  = ctl.en_fd;
    assign EN_DE  = ctl.en_de;
    assign EN_EM  = ctl.en_em;
    assign EN_MW  = ctl.en_mw;
    assign CLR_FD = ctl.clr_fd;
    assign CLR_DE = ctl.clr_de;
    assign CLR_MW = ctl.clr_mw;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .clr(1'b0),
        .inc(stall_m),
        .cnt(stall_cnt)
    );

endmodule
